// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between the CPU and the
// debug/program-loader port. Each granted access runs IDLE -> BUSY -> RESP.
// BUSY holds the latched payload on the memory for WAIT cycles. RESP returns
// a one-cycle acknowledge to the owner. Ties between the two requesters
// alternate round-robin.
module mem_port_arbiter #(
    parameter int WIDTH = 32,
    parameter int WAIT  = 2,   // memory latency, 1..15
    parameter int CNTW  = 4    // must be able to hold WAIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             dbg_req,
    input  logic             dbg_we,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    output logic             dbg_ack,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q;
    logic [CNTW-1:0]  cnt_q;
    logic             owner_q;      // 1 = debug port owns the access
    logic             last_q;       // 1 = debug port was granted last
    logic             owner_d;
    logic             mem_en_q, mem_we_q, busy_q, cpu_ack_q, dbg_ack_q;
    logic [WIDTH-1:0] mem_addr_q, mem_wdata_q, cpu_rdata_q, dbg_rdata_q;

    // Winner selection: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        owner_d = dbg_req & (~cpu_req | ~last_q);
    end

    // Access sequencer: grant, hold the memory for WAIT cycles, capture, acknowledge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: rdata registers are reset too, because their value is visible on ports.
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch sees the pre-edge state.
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        owner_q     <= owner_d;
                        mem_we_q    <= owner_d ? dbg_we    : cpu_we;
                        mem_addr_q  <= owner_d ? dbg_addr  : cpu_addr;
                        mem_wdata_q <= owner_d ? dbg_wdata : cpu_wdata;
                        cnt_q       <= CNTW'(WAIT - 1);
                        mem_en_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        if (!mem_we_q) begin
                            if (owner_q) dbg_rdata_q <= mem_rdata;
                            else         cpu_rdata_q <= mem_rdata;
                        end
                        last_q    <= owner_q;
                        mem_en_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        cpu_ack_q <= ~owner_q;
                        dbg_ack_q <= owner_q;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    // Always return to IDLE, so a held request is resampled there.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu_ack   = cpu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: WAIT=2 main instance with a scoreboard of
// expected acknowledges, plus a WAIT=1 instance for the dropped-request case.
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int WT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Main instance (WAIT=2)
    logic         cpu_req, cpu_we, dbg_req, dbg_we;
    logic [W-1:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic         cpu_ack, dbg_ack, mem_en, mem_we, busy;
    logic [W-1:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

    // Second instance (WAIT=1), CPU side only
    logic         cpu_req1;
    logic [W-1:0] cpu_addr1;
    logic         cpu_ack1, dbg_ack1, mem_en1, mem_we1, busy1;
    logic [W-1:0] cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         is_dbg;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] exp_cpu_rd, exp_dbg_rd;

    // Memory model: read data is a fixed function of the address.
    function automatic logic [W-1:0] rd_model(input logic [W-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata  = rd_model(mem_addr);
    assign mem_rdata1 = rd_model(mem_addr1);

    mem_port_arbiter #(.WIDTH(W), .WAIT(WT), .CNTW(4)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.WIDTH(W), .WAIT(1), .CNTW(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req1), .cpu_we(1'b0), .cpu_addr(cpu_addr1), .cpu_wdata(32'h0),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'h0), .dbg_wdata(32'h0),
        .dbg_ack(dbg_ack1), .dbg_rdata(dbg_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && (cpu_ack || dbg_ack)) begin
            check("ack_exclusive", W'(cpu_ack & dbg_ack), 0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", W'(sb_q.size()), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_port", W'(dbg_ack), W'(mon_e.is_dbg));
                check("ack_rdata", dbg_ack ? dbg_rdata : cpu_rdata, mon_e.rdata);
            end
        end
    end

    task automatic push_exp(input logic is_dbg, input logic we, input logic [W-1:0] addr);
        exp_t e;
        if (!we) begin
            if (is_dbg) exp_dbg_rd = rd_model(addr);
            else        exp_cpu_rd = rd_model(addr);
        end
        e.is_dbg = is_dbg;
        e.rdata  = is_dbg ? exp_dbg_rd : exp_cpu_rd;
        sb_q.push_back(e);
    endtask

    // Follows one access from the negedge before its grant until its ack.
    task automatic track(input logic is_dbg, input logic we, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input logic chg, input logic [W-1:0] new_addr);
        int   n;
        int   en_cnt;
        logic seen;
        n = 0; en_cnt = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (chg && n == 1) begin
                if (is_dbg) dbg_addr = new_addr;
                else        cpu_addr = new_addr;
            end
            if (mem_en) begin
                en_cnt++;
                check("mem_we",    W'(mem_we), W'(we));
                check("mem_addr",  mem_addr,   addr);
                check("mem_wdata", mem_wdata,  wdata);
            end
            if (cpu_ack || dbg_ack) seen = 1'b1;
        end
        check("ack_seen",      W'(seen),   1);
        check("latency",       W'(n),      W'(WT + 1));
        check("mem_en_cycles", W'(en_cnt), W'(WT));
        if (is_dbg) dbg_req = 1'b0;
        else        cpu_req = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", W'(cpu_ack | dbg_ack), 0);
        check("idle_after",    W'(busy), 0);
    endtask

    task automatic do_access(input logic is_dbg, input logic we, input logic [W-1:0] addr,
                             input logic [W-1:0] wdata, input logic chg, input logic [W-1:0] new_addr);
        push_exp(is_dbg, we, addr);
        @(negedge clk);
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        track(is_dbg, we, addr, wdata, chg, new_addr);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        exp_cpu_rd = '0;
        exp_dbg_rd = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int last_n;
        int n;
        int acks;
        int ens;
        logic seen;

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        cpu_req1 = 0; cpu_addr1 = 0;
        exp_cpu_rd = '0; exp_dbg_rd = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_mem_en",    W'(mem_en),  0);
        check("rst_mem_we",    W'(mem_we),  0);
        check("rst_busy",      W'(busy),    0);
        check("rst_acks",      W'({cpu_ack, dbg_ack}), 0);
        check("rst_mem_addr",  mem_addr,    0);
        check("rst_mem_wdata", mem_wdata,   0);
        check("rst_cpu_rdata", cpu_rdata,   0);
        check("rst_dbg_rdata", dbg_rdata,   0);
        reset = 1'b0;

        // CPU read of 0x10
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        check("cpu_read_data", cpu_rdata, 32'hDEAD_BEEF);

        // Debug write leaves dbg_rdata untouched
        do_access(1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0);
        check("dbg_write_rdata", dbg_rdata, 32'h0);

        // Debug read, then CPU address change after grant is ignored
        do_access(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
        do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 32'h40);
        check("cpu_rdata_after_chg", cpu_rdata, 32'hDEAD_BEEF);

        // Continuous contention from reset: CPU, DBG, CPU, DBG every WAIT+2 cycles
        pulse_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h44; dbg_wdata = 0;
        for (int k = 0; k < 4; k++) push_exp(k[0], 1'b0, k[0] ? 32'h44 : 32'h10);
        n = 0; last_n = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 1'b0;
            while (!seen && n < 100) begin
                @(negedge clk);
                n++;
                if (cpu_ack || dbg_ack) seen = 1'b1;
            end
            check("contend_seen", W'(seen), 1);
            check("contend_port", W'(dbg_ack), W'(k % 2));
            if (k == 0) check("contend_first", W'(n), W'(WT + 1));
            else        check("contend_spacing", W'(n - last_n), W'(WT + 2));
            last_n = n;
        end
        cpu_req = 0; dbg_req = 0;
        repeat (2) @(negedge clk);
        check("contend_idle", W'(busy), 0);

        // Reset in the second BUSY cycle aborts; the held request is regranted
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
        repeat (2) @(negedge clk);
        check("pre_abort_mem_en", W'(mem_en), 1);
        #1 reset = 1'b1;
        #1;
        check("abort_mem_en",   W'(mem_en), 0);
        check("abort_busy",     W'(busy),   0);
        check("abort_ack",      W'({cpu_ack, dbg_ack}), 0);
        check("abort_mem_addr", mem_addr,   0);
        exp_cpu_rd = '0; exp_dbg_rd = '0;
        @(negedge clk);
        reset = 1'b0;
        push_exp(1'b0, 1'b0, 32'h30);
        track(1'b0, 1'b0, 32'h30, cpu_wdata, 1'b0, 32'h0);

        // WAIT=1 instance: req dropped during BUSY, ack still pulses once
        @(negedge clk);
        cpu_req1 = 1; cpu_addr1 = 32'h10;
        @(negedge clk);
        check("w1_mem_en", W'(mem_en1), 1);
        cpu_req1 = 0;
        @(negedge clk);
        check("w1_ack",   W'(cpu_ack1), 1);
        check("w1_rdata", cpu_rdata1, 32'hDEAD_BEEF);
        acks = 0; ens = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack1) acks++;
            if (mem_en1)  ens++;
        end
        check("w1_no_reack",   W'(acks), 0);
        check("w1_no_regrant", W'(ens),  0);

        check("sb_drained", W'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single unified instruction/data memory port of the multicycle processor between two requesters: the CPU and the debug/program-loader port. Each granted access runs through a small state machine that drives the memory for a fixed number of wait cycles, captures read data and returns a one-cycle acknowledge. Simultaneous requests are resolved round-robin. The block sits between the datapath's address/write-data muxes and the memory macro.

## Interface
- WIDTH, 32, address and data width
- WAIT, 2, memory access latency in cycles (legal range 1..15)
- CNTW, 4, wait-counter width; must hold WAIT
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  CPU write enable (1 = write, 0 = read)
- cpu_addr  in  WIDTH  CPU byte address
- cpu_wdata  in  WIDTH  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- cpu_rdata  out  WIDTH  CPU read data; valid while cpu_ack = 1, held afterwards
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/WIDTH/WIDTH  debug port, same meaning as the CPU signals
- dbg_ack  out  1  one-cycle completion pulse to the debug port
- dbg_rdata  out  WIDTH  debug read data; same rules as cpu_rdata
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  WIDTH  memory address (registered)
- mem_wdata  out  WIDTH  memory write data (registered)
- mem_rdata  in  WIDTH  memory read data; valid WAIT cycles after mem_en rises
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req is high, select the winner, latch its we/addr/wdata into mem_we/mem_addr/mem_wdata, load the counter with WAIT-1, set owner, go to BUSY. No request: stay in IDLE.
- Arbitration: a single requester wins outright. On a tie, the requester not granted last wins. The last-grant bit resets to DBG, so the CPU wins the first tie.
- BUSY: mem_en = 1 and the latched payload is held. The counter decrements each cycle.
  - When the counter reaches 0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), update last-grant to owner, go to RESP.
- RESP: assert the owner's ack for exactly one cycle, mem_en = 0, go to IDLE unconditionally.
- Requesters hold req and payload stable until ack. Dropping req during BUSY does not abort: the access completes and ack still pulses. Changes to the payload after grant are ignored.
- The non-owner's ack is never asserted. cpu_ack and dbg_ack are never high together.
- Reset values: state IDLE; mem_en, mem_we, busy, cpu_ack, dbg_ack = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; counter 0; last-grant DBG.
- Reset asserted mid-BUSY or mid-RESP: the access is aborted immediately, no ack is issued, and all outputs take their reset values asynchronously.

## Timing
- Request sampled high in IDLE at edge E0 → mem_en high from E0 for exactly WAIT cycles → rdata captured at edge E0+WAIT → ack high for the cycle E0+WAIT to E0+WAIT+1.
- Request-to-ack latency: WAIT+1 cycles. Minimum spacing between grants: WAIT+2 cycles, because IDLE always takes one cycle.
- A requester still holding req in the ack cycle is not regranted off that same sample. In the following IDLE cycle, req is resampled as a new request.
- The waiting requester under continuous contention is granted at the next IDLE, giving strict alternation.
- mem_we is high through all of BUSY for writes and low otherwise.

## Test plan
- WAIT=2, CPU read addr 0x10, memory returns 0xDEADBEEF: mem_en high 2 cycles, cpu_ack at cycle 3, cpu_rdata = 0xDEADBEEF, dbg_ack stays 0.
- DBG write addr 0x20, data 0x12345678: mem_we = 1 with mem_addr = 0x20 and mem_wdata = 0x12345678 for 2 cycles; dbg_ack pulses once; dbg_rdata unchanged.
- Both requests held continuously from reset: grants go CPU, DBG, CPU, DBG, with acks every 4 cycles (WAIT=2), alternating.
- cpu_addr changed from 0x10 to 0x40 one cycle after grant: mem_addr stays 0x10 through BUSY.
- Reset asserted in the second BUSY cycle: mem_en drops immediately, no ack is issued, and after release a held cpu_req is regranted with full latency.
- WAIT=1, CPU read, then cpu_req dropped during BUSY: ack still pulses after 2 cycles and no second grant occurs.
